// File: rtl/cr_isf_ob_stage_pkg.sv
// Shared definitions for the isf output stage: tuser flag positions, TLV
// length field bounds, tracker states, datapath beat payload and a strobe
// popcount helper.
package cr_isf_ob_stage_pkg;

  localparam int unsigned DP_DATA_W = 64;
  localparam int unsigned DP_STRB_W = 8;
  localparam int unsigned DP_USER_W = 8;

  localparam int unsigned SOT_BIT = 0;
  localparam int unsigned EOT_BIT = 1;

  localparam int unsigned LEN_LSB = 8;
  localparam int unsigned LEN_MSB = 31;
  localparam int unsigned LEN_W   = LEN_MSB - LEN_LSB + 1;

  typedef enum logic {
    IDLE = 1'b0,
    BODY = 1'b1
  } tlv_trk_e;

  // Beat payload carried through the skid buffer (tvalid travels separately)
  typedef struct packed {
    logic                 tlast;
    logic                 tid;
    logic [DP_STRB_W-1:0] tstrb;
    logic [DP_USER_W-1:0] tuser;
    logic [DP_DATA_W-1:0] tdata;
  } axi4s_dp_bus_t;

  typedef struct packed {
    logic tready;
  } axi4s_dp_rdy_t;

  localparam int unsigned DP_BUS_W = $bits(axi4s_dp_bus_t);

  // Number of enabled bytes in a beat, 0..8
  function automatic logic [3:0] strb_popcount(input logic [DP_STRB_W-1:0] strb);
    logic [3:0] n;
    n = 4'd0;
    for (int unsigned i = 0; i < DP_STRB_W; i++) begin
      n = n + 4'(strb[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/cr_isf_ob_skid.sv
// Generic 2-entry skid buffer (main + skid). Full throughput, registered
// ready towards the source, registered valid/data towards the sink.
//   in_valid_i/in_data_i/in_ready_o  : upstream handshake
//   out_valid_o/out_data_o/out_ready_i : downstream handshake
module cr_isf_ob_skid #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid_i,
  input  logic [W-1:0] in_data_i,
  output logic         in_ready_o,
  output logic         out_valid_o,
  output logic [W-1:0] out_data_o,
  input  logic         out_ready_i
);

  logic         main_vld_q, main_vld_d;
  logic         skid_vld_q, skid_vld_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         in_ready_q, in_ready_d;
  logic         push, pop;

  // Occupancy update; skid only fills when main is held by back-pressure
  always_comb begin
    main_vld_d = main_vld_q;
    skid_vld_d = skid_vld_q;
    main_d     = main_q;
    skid_d     = skid_q;
    push       = in_valid_i && in_ready_q;
    pop        = main_vld_q && out_ready_i;

    if (skid_vld_q) begin
      if (pop) begin
        main_d     = skid_q;
        skid_vld_d = 1'b0;
      end
    end else if (main_vld_q) begin
      if (push && pop) begin
        main_d = in_data_i;
      end else if (pop) begin
        main_vld_d = 1'b0;
      end else if (push) begin
        skid_d     = in_data_i;
        skid_vld_d = 1'b1;
      end
    end else if (push) begin
      main_d     = in_data_i;
      main_vld_d = 1'b1;
    end

    in_ready_d = !skid_vld_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = main_vld_q;
  assign out_data_o  = main_q;

endmodule

// File: rtl/cr_isf_ob_stage.sv
// Output stage downstream of the input stream filter. Registers the AXI4-S
// datapath through a 2-entry skid buffer, checks TLV framing on accepted
// input beats, reports forwarded byte counts and flags long back-pressure.
//   in_*            : beat from the filter, in_tready registered back
//   out_*           : beat to downstream, out_tready from downstream
//   stall_limit     : stall-cycle threshold (0 disables), stall_int pulse
//   tlv_err_int     : TLV framing error pulse, tlv_cnt_stb per EoT beat
//   bytes_stb/amt   : one strobe per forwarded beat with its byte count
module cr_isf_ob_stage
  import cr_isf_ob_stage_pkg::*;
#(
  parameter int unsigned DATA_W  = DP_DATA_W,
  parameter int unsigned STRB_W  = DP_STRB_W,
  parameter int unsigned STALL_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_tvalid,
  input  logic               in_tlast,
  input  logic               in_tid,
  input  logic [STRB_W-1:0]  in_tstrb,
  input  logic [7:0]         in_tuser,
  input  logic [DATA_W-1:0]  in_tdata,
  output logic               in_tready,
  output logic               out_tvalid,
  output logic               out_tlast,
  output logic               out_tid,
  output logic [STRB_W-1:0]  out_tstrb,
  output logic [7:0]         out_tuser,
  output logic [DATA_W-1:0]  out_tdata,
  input  logic               out_tready,
  input  logic [STALL_W-1:0] stall_limit,
  output logic               stall_int,
  output logic               tlv_err_int,
  output logic               bytes_stb,
  output logic [3:0]         bytes_amt,
  output logic               tlv_cnt_stb
);

  axi4s_dp_bus_t in_beat, out_beat;
  axi4s_dp_rdy_t in_rdy, out_rdy;
  logic          out_vld;
  logic          in_acc, out_pop;

  always_comb begin
    in_beat.tlast = in_tlast;
    in_beat.tid   = in_tid;
    in_beat.tstrb = in_tstrb;
    in_beat.tuser = in_tuser;
    in_beat.tdata = in_tdata;
  end

  assign out_rdy.tready = out_tready;

  cr_isf_ob_skid #(
    .W (DP_BUS_W)
  ) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_tvalid),
    .in_data_i   (in_beat),
    .in_ready_o  (in_rdy.tready),
    .out_valid_o (out_vld),
    .out_data_o  (out_beat),
    .out_ready_i (out_rdy.tready)
  );

  assign in_acc  = in_tvalid && in_rdy.tready;
  assign out_pop = out_vld && out_rdy.tready;

  // ---------------------------------------------------------------- TLV tracker
  tlv_trk_e         trk_q, trk_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             tlv_err_q, tlv_err_d;
  logic             tlv_stb_q, tlv_stb_d;
  logic [LEN_W-1:0] in_len;
  logic [LEN_W:0]   cnt_inc;
  logic             sot, eot;

  always_comb begin
    trk_d     = trk_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    tlv_err_d = 1'b0;
    tlv_stb_d = 1'b0;
    in_len    = in_beat.tdata[LEN_MSB:LEN_LSB];
    sot       = in_beat.tuser[SOT_BIT];
    eot       = in_beat.tuser[EOT_BIT];
    cnt_inc   = {1'b0, cnt_q} + (LEN_W+1)'(1);

    if (in_acc) begin
      tlv_stb_d = eot;
      if (sot) begin
        // A header inside an open TLV is reported, then tracking restarts here
        tlv_err_d = (trk_q == BODY);
        len_d     = in_len;
        cnt_d     = LEN_W'(1);
        if (eot) begin
          if (in_len != LEN_W'(1)) tlv_err_d = 1'b1;
          trk_d = IDLE;
        end else begin
          trk_d = BODY;
        end
      end else if (trk_q == IDLE) begin
        tlv_err_d = 1'b1;
      end else begin
        if (!(&cnt_q)) cnt_d = cnt_inc[LEN_W-1:0];
        if (eot) begin
          // Saturated count yields 2^24 here, which never matches a length
          if (cnt_inc != {1'b0, len_q}) tlv_err_d = 1'b1;
          trk_d = IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trk_q     <= IDLE;
      len_q     <= '0;
      cnt_q     <= '0;
      tlv_err_q <= 1'b0;
      tlv_stb_q <= 1'b0;
    end else begin
      trk_q     <= trk_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      tlv_err_q <= tlv_err_d;
      tlv_stb_q <= tlv_stb_d;
    end
  end

  // ---------------------------------------------------------------- byte stats
  logic       bytes_stb_q, bytes_stb_d;
  logic [3:0] bytes_amt_q, bytes_amt_d;

  always_comb begin
    bytes_stb_d = out_pop;
    bytes_amt_d = out_pop ? strb_popcount(out_beat.tstrb) : 4'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bytes_stb_q <= 1'b0;
      bytes_amt_q <= 4'd0;
    end else begin
      bytes_stb_q <= bytes_stb_d;
      bytes_amt_q <= bytes_amt_d;
    end
  end

  // ---------------------------------------------------------------- stall monitor
  logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
  logic               stall_fired_q, stall_fired_d;
  logic               stall_int_q, stall_int_d;
  logic               stalled;

  // Equality compare: a limit lowered below the running count waits for the next episode
  always_comb begin
    stall_cnt_d   = stall_cnt_q;
    stall_fired_d = stall_fired_q;
    stall_int_d   = 1'b0;
    stalled       = out_vld && !out_rdy.tready;

    if (!stalled) begin
      stall_cnt_d   = '0;
      stall_fired_d = 1'b0;
    end else begin
      if (!(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + STALL_W'(1);
      if (!stall_fired_q && (stall_limit != '0) && (stall_cnt_d == stall_limit)) begin
        stall_int_d   = 1'b1;
        stall_fired_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q   <= '0;
      stall_fired_q <= 1'b0;
      stall_int_q   <= 1'b0;
    end else begin
      stall_cnt_q   <= stall_cnt_d;
      stall_fired_q <= stall_fired_d;
      stall_int_q   <= stall_int_d;
    end
  end

  // ---------------------------------------------------------------- outputs
  assign in_tready   = in_rdy.tready;
  assign out_tvalid  = out_vld;
  assign out_tlast   = out_beat.tlast;
  assign out_tid     = out_beat.tid;
  assign out_tstrb   = out_beat.tstrb;
  assign out_tuser   = out_beat.tuser;
  assign out_tdata   = out_beat.tdata;
  assign stall_int   = stall_int_q;
  assign tlv_err_int = tlv_err_q;
  assign tlv_cnt_stb = tlv_stb_q;
  assign bytes_stb   = bytes_stb_q;
  assign bytes_amt   = bytes_amt_q;

endmodule
